// File: rtl/mod_link_pkg.sv
// Shared link constants, frame tags and builder FSM state.
// Also used by the serializer and the receive demux.
package mod_link_pkg;

    localparam int CH_WIDTH  = 24;
    localparam int NUM_CH    = 8;
    localparam int DATA_SIZE = NUM_CH * CH_WIDTH + 2;

    localparam logic [1:0] TAG_A = 2'b01;
    localparam logic [1:0] TAG_B = 2'b10;

    typedef enum logic {
        COLLECT,
        TRANSFER
    } state_t;

endpackage

// File: rtl/mod_frame_builder_if.sv
// Sample intake and frame hand-off bundle.
// The serializer side drives FRAME_LOAD.
interface mod_frame_builder_if #(
    parameter int CH_WIDTH  = mod_link_pkg::CH_WIDTH,
    parameter int NUM_CH    = mod_link_pkg::NUM_CH,
    parameter int DATA_SIZE = mod_link_pkg::DATA_SIZE
);

    logic                      SAMPLE_VALID;
    logic [$clog2(NUM_CH)-1:0] SAMPLE_CH;
    logic [CH_WIDTH-1:0]       SAMPLE_DATA;
    logic                      SAMPLE_READY;
    logic                      FRAME_LOAD;
    logic [DATA_SIZE-1:0]      FRAME_DATA;
    logic                      FRAME_VALID;
    logic [15:0]               FRAME_CNT;
    logic                      DUP_ERR;
    logic                      UNDERRUN;

    modport master (
        output SAMPLE_VALID, SAMPLE_CH, SAMPLE_DATA, FRAME_LOAD,
        input  SAMPLE_READY, FRAME_DATA, FRAME_VALID,
        input  FRAME_CNT, DUP_ERR, UNDERRUN
    );

    modport slave (
        input  SAMPLE_VALID, SAMPLE_CH, SAMPLE_DATA, FRAME_LOAD,
        output SAMPLE_READY, FRAME_DATA, FRAME_VALID,
        output FRAME_CNT, DUP_ERR, UNDERRUN
    );

endinterface

// File: rtl/mod_frame_builder.sv
// Packs NUM_CH channel samples plus an alternating tag into one frame
// and holds it in an output register until the serializer loads it.
module mod_frame_builder #(
    parameter int CH_WIDTH  = mod_link_pkg::CH_WIDTH,
    parameter int NUM_CH    = mod_link_pkg::NUM_CH,
    parameter int DATA_SIZE = mod_link_pkg::DATA_SIZE
) (
    input logic               CLK,
    input logic               RESET,
    mod_frame_builder_if.slave bus
);

    import mod_link_pkg::*;

    state_t state;
    state_t state_nxt;

    logic                 ready;
    logic                 ready_nxt;
    logic [NUM_CH-1:0]    mask;
    logic [NUM_CH-1:0]    mask_nxt;
    logic [NUM_CH-1:0]    ch_bit;
    logic [CH_WIDTH-1:0]  slots [NUM_CH];
    logic [1:0]           tag;
    logic [DATA_SIZE-1:0] frame_nxt;
    logic [DATA_SIZE-1:0] fdata;
    logic                 fvalid;
    logic [15:0]          fcnt;
    logic                 dup_err;
    logic                 underrun;
    logic                 accept;
    logic                 dup;
    logic                 out_free;
    logic                 xfer;

    assign accept   = bus.SAMPLE_VALID & ready;
    assign ch_bit   = {{(NUM_CH-1){1'b0}}, 1'b1} << bus.SAMPLE_CH;
    assign dup      = accept & |(mask & ch_bit);
    // A load on this edge frees the holding register for a same-edge transfer
    assign out_free = ~fvalid | bus.FRAME_LOAD;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        xfer      = 1'b0;
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    mask_nxt = mask | ch_bit;
                end
                if (&mask_nxt) begin
                    state_nxt = TRANSFER;
                end
            end
            TRANSFER: begin
                if (out_free) begin
                    xfer      = 1'b1;
                    mask_nxt  = '0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
        ready_nxt = (state_nxt == COLLECT);
    end

    always_comb begin
        frame_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            frame_nxt[i*CH_WIDTH +: CH_WIDTH] = slots[i];
        end
        frame_nxt[DATA_SIZE-1 -: 2] = tag;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                slots[i] <= '0;
            end
        end else if (accept) begin
            slots[bus.SAMPLE_CH] <= bus.SAMPLE_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mask     <= '0;
            ready    <= 1'b0;
            tag      <= TAG_A;
            fdata    <= '0;
            fvalid   <= 1'b0;
            fcnt     <= '0;
            dup_err  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            mask  <= mask_nxt;
            ready <= ready_nxt;
            if (dup) begin
                dup_err <= 1'b1;
            end
            if (bus.FRAME_LOAD & ~fvalid) begin
                underrun <= 1'b1;
            end
            if (xfer) begin
                fdata  <= frame_nxt;
                fvalid <= 1'b1;
                fcnt   <= fcnt + 16'd1;
                tag    <= (tag == TAG_A) ? TAG_B : TAG_A;
            end else if (bus.FRAME_LOAD) begin
                fvalid <= 1'b0;
            end
        end
    end

    assign bus.SAMPLE_READY = ready;
    assign bus.FRAME_DATA   = fdata;
    assign bus.FRAME_VALID  = fvalid;
    assign bus.FRAME_CNT    = fcnt;
    assign bus.DUP_ERR      = dup_err;
    assign bus.UNDERRUN     = underrun;

endmodule

// File: tb/tb_mod_frame_builder.sv
// Directed vectors and corner sequences for mod_frame_builder.
module tb_mod_frame_builder;

    import mod_link_pkg::*;

    typedef struct {
        logic        v;
        logic [2:0]  ch;
        logic [23:0] d;
        logic        ld;
        logic        rdy;
        logic        fv;
        logic [15:0] cnt;
        logic        dup;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_slot [8];
    vec_t        tbl [9];

    mod_frame_builder_if bus ();

    mod_frame_builder dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(logic [2:0] ch, logic [23:0] d);
        bus.SAMPLE_VALID = 1'b1;
        bus.SAMPLE_CH    = ch;
        bus.SAMPLE_DATA  = d;
        tick();
        bus.SAMPLE_VALID = 1'b0;
    endtask

    task automatic pulse_load();
        bus.FRAME_LOAD = 1'b1;
        tick();
        bus.FRAME_LOAD = 1'b0;
    endtask

    function automatic logic [DATA_SIZE-1:0] model(logic [1:0] t);
        logic [DATA_SIZE-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*24 +: 24] = exp_slot[i];
        end
        r[193:192] = t;
        return r;
    endfunction

    task automatic chk_reset_outs(string tagname);
        chk({tagname, "_rdy"}, bus.SAMPLE_READY, 0);
        chk({tagname, "_fv"}, bus.FRAME_VALID, 0);
        chk({tagname, "_data"}, bus.FRAME_DATA, 0);
        chk({tagname, "_cnt"}, bus.FRAME_CNT, 0);
        chk({tagname, "_dup"}, bus.DUP_ERR, 0);
        chk({tagname, "_und"}, bus.UNDERRUN, 0);
    endtask

    initial begin
        logic [DATA_SIZE-1:0] fd;
        bus.SAMPLE_VALID = 1'b0;
        bus.SAMPLE_CH    = '0;
        bus.SAMPLE_DATA  = '0;
        bus.FRAME_LOAD   = 1'b0;

        tick();
        tick();
        chk_reset_outs("reset");
        RESET = 1'b0;
        tick();
        chk("ready_after_release", bus.SAMPLE_READY, 1);

        // Load on an empty holding register
        pulse_load();
        chk("underrun_set", bus.UNDERRUN, 1);
        chk("underrun_fv", bus.FRAME_VALID, 0);
        chk("underrun_data", bus.FRAME_DATA, 0);

        RESET = 1'b1;
        #2;
        chk("underrun_cleared", bus.UNDERRUN, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        tick();
        chk("ready_after_reset2", bus.SAMPLE_READY, 1);

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 3'(i), 24'(i + 1), 1'b0,
                       (i < 7), 1'b0, 16'd0, 1'b0};
        end
        tbl[8] = '{1'b0, 3'd0, 24'd0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            bus.SAMPLE_VALID = tbl[i].v;
            bus.SAMPLE_CH    = tbl[i].ch;
            bus.SAMPLE_DATA  = tbl[i].d;
            bus.FRAME_LOAD   = tbl[i].ld;
            tick();
            chk($sformatf("vec%0d", i),
                {bus.SAMPLE_READY, bus.FRAME_VALID,
                 bus.FRAME_CNT, bus.DUP_ERR},
                {tbl[i].rdy, tbl[i].fv, tbl[i].cnt, tbl[i].dup});
        end
        bus.SAMPLE_VALID = 1'b0;
        fd = bus.FRAME_DATA;
        chk("f1_ch0", fd[23:0], 24'h000001);
        chk("f1_ch7", fd[191:168], 24'h000008);
        chk("f1_tag", fd[193:192], TAG_A);
        for (int i = 0; i < 8; i++) exp_slot[i] = 24'(i + 1);
        chk("f1_frame", fd, model(TAG_A));

        // Second frame stalls behind an unsent frame
        for (int i = 0; i < 8; i++) begin
            exp_slot[i] = 24'h10 + 24'(i);
            send(3'(i), exp_slot[i]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d", k),
                {bus.SAMPLE_READY, bus.FRAME_VALID, bus.FRAME_CNT},
                {1'b0, 1'b1, 16'd1});
        end
        pulse_load();
        chk("f2_fv", bus.FRAME_VALID, 1);
        chk("f2_cnt", bus.FRAME_CNT, 2);
        chk("f2_frame", bus.FRAME_DATA, model(TAG_B));
        chk("f2_rdy", bus.SAMPLE_READY, 1);

        // Load coincides with the transfer edge
        for (int i = 0; i < 8; i++) begin
            exp_slot[i] = 24'h20 + 24'(i);
            send(3'(i), exp_slot[i]);
        end
        chk("f3_transfer_rdy", bus.SAMPLE_READY, 0);
        pulse_load();
        chk("f3_fv", bus.FRAME_VALID, 1);
        chk("f3_frame", bus.FRAME_DATA, model(TAG_A));
        chk("f3_cnt", bus.FRAME_CNT, 3);
        tick();
        chk("f3_cnt_hold", {bus.FRAME_VALID, bus.FRAME_CNT}, {1'b1, 16'd3});
        pulse_load();
        chk("drain_fv", bus.FRAME_VALID, 0);
        chk("drain_und", bus.UNDERRUN, 0);

        // Duplicate channel 3
        for (int i = 0; i < 8; i++) exp_slot[i] = 24'h50 + 24'(i);
        for (int i = 0; i < 3; i++) send(3'(i), exp_slot[i]);
        send(3'd3, 24'hAAAAAA);
        chk("dup_first", bus.DUP_ERR, 0);
        send(3'd3, 24'h555555);
        exp_slot[3] = 24'h555555;
        chk("dup_second", bus.DUP_ERR, 1);
        for (int i = 4; i < 7; i++) send(3'(i), exp_slot[i]);
        chk("dup_no_early",
            {bus.SAMPLE_READY, bus.FRAME_VALID}, {1'b1, 1'b0});
        send(3'd7, exp_slot[7]);
        tick();
        chk("dup_fv", bus.FRAME_VALID, 1);
        chk("dup_cnt", bus.FRAME_CNT, 4);
        chk("dup_slot3", bus.FRAME_DATA[95:72], 24'h555555);
        chk("dup_frame", bus.FRAME_DATA, model(TAG_B));

        // Reset after 5 of 8 samples
        for (int i = 0; i < 5; i++) send(3'(i), 24'h60 + 24'(i));
        RESET = 1'b1;
        #2;
        chk_reset_outs("midreset");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            exp_slot[i] = 24'h70 + 24'(i);
            send(3'(i), exp_slot[i]);
        end
        tick();
        chk("post_reset_frame", bus.FRAME_DATA, model(TAG_A));
        chk("post_reset_cnt", bus.FRAME_CNT, 1);
        chk("post_reset_dup", bus.DUP_ERR, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_frame_builder.md
# mod_frame_builder

Upstream feeder for the serial link transmitter. Collects eight 24-bit ADC channel samples over a valid/ready interface and packs them into one 194-bit frame with a 2-bit frame tag. Holds the packed frame for the serializer, which takes it with a one-cycle load pulse at each frame gap. Provides one assembly buffer plus one output holding register, so the next frame is collected while the current one is shifted out.

## Interface
Parameters:
- CH_WIDTH, 24, bits per channel sample
- NUM_CH, 8, channels per frame (SAMPLE_CH width = clog2(NUM_CH))
- DATA_SIZE, 194, frame width; must equal NUM_CH*CH_WIDTH+2

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- SAMPLE_VALID  in  1  sample present
- SAMPLE_CH  in  3  channel index of sample
- SAMPLE_DATA  in  CH_WIDTH  sample value
- SAMPLE_READY  out  1  block accepts sample this cycle
- FRAME_LOAD  in  1  one-cycle pulse from serializer: frame latched
- FRAME_DATA  out  DATA_SIZE  packed frame
- FRAME_VALID  out  1  FRAME_DATA holds an unsent frame
- FRAME_CNT  out  16  frames transferred to output register
- DUP_ERR  out  1  sticky: channel written twice in one frame
- UNDERRUN  out  1  sticky: FRAME_LOAD with FRAME_VALID low

## Operation
- Layout: FRAME_DATA[CH_WIDTH*i +: CH_WIDTH] = channel i; FRAME_DATA[193:192] = tag. Serializer sends bit 0 first.
- Tag alternates 2'b01, 2'b10, 2'b01, ... starting at 2'b01 after reset; it advances on every transfer to the output register.
- Accept = SAMPLE_VALID & SAMPLE_READY. Writes SAMPLE_DATA into slot SAMPLE_CH and sets bit SAMPLE_CH of the 8-bit fill mask.
- Accepting a channel whose mask bit is already set overwrites the slot and sets DUP_ERR.
- States:
  - COLLECT: SAMPLE_READY=1. When the mask becomes all-ones, go to TRANSFER.
  - TRANSFER: SAMPLE_READY=0. If the output register is free (FRAME_VALID=0, or FRAME_LOAD=1 this cycle), copy the assembly buffer plus tag to the output register, set FRAME_VALID=1, increment FRAME_CNT, clear the mask, and return to COLLECT. Otherwise stay in TRANSFER.
- FRAME_LOAD with FRAME_VALID=1 clears FRAME_VALID, unless a transfer happens on the same edge; in that case FRAME_VALID stays 1 with the new data.
- FRAME_LOAD with FRAME_VALID=0 sets UNDERRUN. FRAME_DATA is unchanged, so the serializer resends the last frame.
- FRAME_CNT wraps 0xFFFF -> 0x0000.
- DUP_ERR and UNDERRUN clear only on RESET.

## Timing
- Reset values:
  - FRAME_DATA=0, FRAME_VALID=0, FRAME_CNT=0, DUP_ERR=0, UNDERRUN=0
  - SAMPLE_READY=0 while RESET is high, then 1 from the first cycle after release
  - state=COLLECT, mask=0, next tag=2'b01
- Accepting the 8th distinct channel at edge N causes TRANSFER from N; SAMPLE_READY=0 after N.
- With the output free, FRAME_VALID/FRAME_DATA update at edge N+1, and SAMPLE_READY=1 after N+1. Minimum frame period is 9 cycles.
- With the output busy, the transfer occurs on the edge where FRAME_LOAD=1. SAMPLE_READY returns to 1 the cycle after that edge.
- SAMPLE_READY is a registered state decode; it does not depend combinationally on SAMPLE_VALID.
- RESET mid-frame discards the partial mask and the held frame immediately (asynchronous); no partial frame is ever emitted.

## Structure
- Shared package mod_link_pkg holds:
  - CH_WIDTH, NUM_CH, DATA_SIZE
  - TAG_A=2'b01, TAG_B=2'b10
  - state enum {COLLECT, TRANSFER}
- The same package is used by the serializer and the receive demux, which routes frames on bits [193:192].
- Single module; no sub-module. The assembly buffer is NUM_CH registers of CH_WIDTH bits.

## Test plan
- Reset, then channels 0..7 with values 0x000001..0x000008, no FRAME_LOAD:
  - FRAME_VALID=1 one cycle after the 8th accept
  - FRAME_DATA[23:0]=1, FRAME_DATA[191:168]=8, [193:192]=2'b01, FRAME_CNT=1
- Two more full frames with no FRAME_LOAD:
  - Second frame stalls in TRANSFER with SAMPLE_READY=0 for 3+ cycles
  - FRAME_LOAD pulse: FRAME_DATA switches to the second frame, tag 2'b10, FRAME_VALID stays 1, FRAME_CNT=2
- Channel 3 sent twice (0xAAAAAA then 0x555555) within one frame:
  - DUP_ERR=1
  - Frame slot 3 = 0x555555
  - Frame emitted only after all 8 channels are present
- FRAME_LOAD pulse on an empty output register after reset: UNDERRUN=1, FRAME_VALID=0, FRAME_DATA=0.
- Assert RESET after 5 of 8 samples:
  - Outputs return to reset values
  - A following full frame carries only the new samples, with tag 2'b01
- FRAME_LOAD coincident with the TRANSFER edge (output valid):
  - FRAME_VALID stays 1 and FRAME_DATA shows the new frame
  - FRAME_CNT increments exactly once
